control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer_if.sv | 49 ++++
 rtl/control_sequencer.sv | 247 ++++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// Bus between the control sequencer and the datapath it steers.
// The master side (the sequencer) consumes the instruction and memory
// status and drives every datapath strobe. The slave side is the datapath
// or a testbench standing in for it.
interface control_sequencer_if;
  logic [31:0] IR;
  logic        mem_ready;
  logic        stop;

  logic        PCout;
  logic        PCin;
  logic        IncPC;
  logic        MARin;
  logic        MDRin;
  logic        MDRout;
  logic        Read;
  logic        Write;
  logic        IRin;
  logic        Yin;
  logic        Zin;
  logic        Zlowout;
  logic        Cout;

  logic        Gra;
  logic        Grb;
  logic        Grc;
  logic        Rin;
  logic        Rout;
  logic        BAout;

  logic [4:0]  alu_op;
  logic        Run;

  modport master (
    input  IR, mem_ready, stop,
    output PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin,
           Yin, Zin, Zlowout, Cout,
           Gra, Grb, Grc, Rin, Rout, BAout,
           alu_op, Run
  );

  modport slave (
    output IR, mem_ready, stop,
    input  PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin,
           Yin, Zin, Zlowout, Cout,
           Gra, Grb, Grc, Rin, Rout, BAout,
           alu_op, Run
  );
endinterface

// File: rtl/control_sequencer.sv
// Moore control sequencer for a small load/store CPU.
// The state register walks fetch (T0..T2) and execute (T3..T7). Every
// strobe is decoded from the current state and the opcode in IR[31:27].
// A stop request is latched and honoured only when the current
// instruction has finished. HALT is left only through reset.
module control_sequencer (
  input  logic                  clock,
  input  logic                  reset,
  control_sequencer_if.master   bus
);

  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_T7   = 4'd8,
    S_HALT = 4'd9
  } state_e;

  typedef enum logic [2:0] {
    C_LD,
    C_LDI,
    C_ST,
    C_RTYPE,
    C_IMM,
    C_HALT,
    C_NOP
  } op_class_e;

  localparam logic [4:0] ALU_NONE = 5'b00000;
  localparam logic [4:0] ALU_ADD  = 5'b00011;
  localparam logic [4:0] ALU_AND  = 5'b00101;
  localparam logic [4:0] ALU_OR   = 5'b00110;

  state_e    state_q, state_d;
  logic      stop_pending_q, stop_pending_d;
  logic [4:0] opcode;
  op_class_e op_class;
  logic      run_state;
  logic      halt_req;
  state_e    end_state;

  // Unlisted opcodes behave as nop: fetch, then go straight back to T0.
  function automatic op_class_e classify(input logic [4:0] op);
    case (op)
      5'b00000:                               classify = C_LD;
      5'b00001:                               classify = C_LDI;
      5'b00010:                               classify = C_ST;
      5'b00011, 5'b00100, 5'b00101, 5'b00110: classify = C_RTYPE;
      5'b01100, 5'b01101, 5'b01110:           classify = C_IMM;
      5'b11011:                               classify = C_HALT;
      default:                                classify = C_NOP;
    endcase
  endfunction

  // Immediate forms reuse the ALU codes of their register-register twins.
  function automatic logic [4:0] imm_alu(input logic [4:0] op);
    case (op)
      5'b01101: imm_alu = ALU_AND;
      5'b01110: imm_alu = ALU_OR;
      default:  imm_alu = ALU_ADD;
    endcase
  endfunction

  assign opcode    = bus.IR[31:27];
  assign op_class  = classify(opcode);
  assign run_state = (state_q != S_RST) && (state_q != S_HALT);
  // A stop seen in the last cycle of an instruction halts right away
  // rather than letting another instruction start.
  assign halt_req  = stop_pending_q | bus.stop;
  assign end_state = halt_req ? S_HALT : S_T0;

  // Next-state and stop-latch logic.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first, so no path can leave it unassigned and infer a latch.
    state_d        = state_q;
    stop_pending_d = stop_pending_q | (bus.stop & run_state);
    case (state_q)
      S_RST:  state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = bus.mem_ready ? S_T2 : S_T1;
      S_T2: begin
        case (op_class)
          C_NOP:   state_d = end_state;
          C_HALT:  state_d = S_HALT;
          default: state_d = S_T3;
        endcase
      end
      // IR should not change during execute. If it does and now holds a
      // nop or halt, the instruction is ended cleanly.
      S_T3:   state_d = (op_class == C_NOP || op_class == C_HALT) ? end_state : S_T4;
      S_T4:   state_d = S_T5;
      S_T5:   state_d = (op_class == C_LD || op_class == C_ST) ? S_T6 : end_state;
      S_T6: begin
        case (op_class)
          C_LD:    state_d = bus.mem_ready ? S_T7 : S_T6;
          C_ST:    state_d = S_T7;
          default: state_d = end_state;
        endcase
      end
      S_T7: begin
        if (op_class == C_ST && !bus.mem_ready) state_d = S_T7;
        else                                    state_d = end_state;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  // State register. Reset is synchronous and beats stop and mem_ready.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values and the order of updates does not matter.
    if (reset) begin
      state_q        <= S_RST;
      stop_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      stop_pending_q <= stop_pending_d;
    end
  end

  // Moore output decode from the state register and the opcode.
  always_comb begin
    bus.PCout   = 1'b0;
    bus.PCin    = 1'b0;
    bus.IncPC   = 1'b0;
    bus.MARin   = 1'b0;
    bus.MDRin   = 1'b0;
    bus.MDRout  = 1'b0;
    bus.Read    = 1'b0;
    bus.Write   = 1'b0;
    bus.IRin    = 1'b0;
    bus.Yin     = 1'b0;
    bus.Zin     = 1'b0;
    bus.Zlowout = 1'b0;
    bus.Cout    = 1'b0;
    bus.Gra     = 1'b0;
    bus.Grb     = 1'b0;
    bus.Grc     = 1'b0;
    bus.Rin     = 1'b0;
    bus.Rout    = 1'b0;
    bus.BAout   = 1'b0;
    bus.alu_op  = ALU_NONE;
    bus.Run     = run_state;
    case (state_q)
      S_T0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.IncPC = 1'b1;
        bus.Zin   = 1'b1;
      end
      S_T1: begin
        bus.Zlowout = 1'b1;
        bus.PCin    = 1'b1;
        bus.Read    = 1'b1;
        bus.MDRin   = 1'b1;
      end
      S_T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      S_T3: begin
        // Y takes rb, or the base address (r0 reads as zero) for ldi/ld/st.
        case (op_class)
          C_RTYPE, C_IMM: begin
            bus.Grb  = 1'b1;
            bus.Rout = 1'b1;
            bus.Yin  = 1'b1;
          end
          C_LD, C_LDI, C_ST: begin
            bus.Grb   = 1'b1;
            bus.BAout = 1'b1;
            bus.Yin   = 1'b1;
          end
          default: ;
        endcase
      end
      S_T4: begin
        case (op_class)
          C_RTYPE: begin
            bus.Grc    = 1'b1;
            bus.Rout   = 1'b1;
            bus.Zin    = 1'b1;
            bus.alu_op = opcode;
          end
          C_IMM: begin
            bus.Cout   = 1'b1;
            bus.Zin    = 1'b1;
            bus.alu_op = imm_alu(opcode);
          end
          C_LD, C_LDI, C_ST: begin
            bus.Cout   = 1'b1;
            bus.Zin    = 1'b1;
            bus.alu_op = ALU_ADD;
          end
          default: ;
        endcase
      end
      S_T5: begin
        case (op_class)
          C_RTYPE, C_IMM, C_LDI: begin
            bus.Zlowout = 1'b1;
            bus.Gra     = 1'b1;
            bus.Rin     = 1'b1;
          end
          C_LD, C_ST: begin
            bus.Zlowout = 1'b1;
            bus.MARin   = 1'b1;
          end
          default: ;
        endcase
      end
      S_T6: begin
        case (op_class)
          C_LD: begin
            bus.Read  = 1'b1;
            bus.MDRin = 1'b1;
          end
          C_ST: begin
            bus.Gra   = 1'b1;
            bus.Rout  = 1'b1;
            bus.MDRin = 1'b1;
          end
          default: ;
        endcase
      end
      S_T7: begin
        case (op_class)
          C_LD: begin
            bus.MDRout = 1'b1;
            bus.Gra    = 1'b1;
            bus.Rin    = 1'b1;
          end
          C_ST: bus.Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Cycle-by-cycle directed bench for control_sequencer. Each table record
// holds the inputs for one clock cycle and the outputs expected during
// that cycle. Inputs are driven on the falling edge and outputs are checked
// 1 ns later, well away from the rising edge.
module tb_control_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;

  control_sequencer_if bus_if ();

  control_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clock = ~clock;

  // Strobe bit positions, MSB first:
  // PCout PCin IncPC MARin MDRin MDRout Read Write IRin Yin Zin Zlowout Cout
  // Gra Grb Grc Rin Rout BAout
  localparam logic [18:0] M_PCOUT   = 19'b1 << 18;
  localparam logic [18:0] M_PCIN    = 19'b1 << 17;
  localparam logic [18:0] M_INCPC   = 19'b1 << 16;
  localparam logic [18:0] M_MARIN   = 19'b1 << 15;
  localparam logic [18:0] M_MDRIN   = 19'b1 << 14;
  localparam logic [18:0] M_MDROUT  = 19'b1 << 13;
  localparam logic [18:0] M_READ    = 19'b1 << 12;
  localparam logic [18:0] M_WRITE   = 19'b1 << 11;
  localparam logic [18:0] M_IRIN    = 19'b1 << 10;
  localparam logic [18:0] M_YIN     = 19'b1 << 9;
  localparam logic [18:0] M_ZIN     = 19'b1 << 8;
  localparam logic [18:0] M_ZLOWOUT = 19'b1 << 7;
  localparam logic [18:0] M_COUT    = 19'b1 << 6;
  localparam logic [18:0] M_GRA     = 19'b1 << 5;
  localparam logic [18:0] M_GRB     = 19'b1 << 4;
  localparam logic [18:0] M_GRC     = 19'b1 << 3;
  localparam logic [18:0] M_RIN     = 19'b1 << 2;
  localparam logic [18:0] M_ROUT    = 19'b1 << 1;
  localparam logic [18:0] M_BAOUT   = 19'b1 << 0;
  localparam logic [18:0] NONE      = 19'b0;

  localparam logic [18:0] F_T0 = M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
  localparam logic [18:0] F_T1 = M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN;
  localparam logic [18:0] F_T2 = M_MDROUT | M_IRIN;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_HALT = 5'b11011;
  localparam logic [4:0] OP_UNK  = 5'b10101;

  typedef struct {
    logic        rst;
    logic [4:0]  op;
    logic        mr;
    logic        stp;
    logic [18:0] strb;
    logic [4:0]  alu;
    logic        run;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic add(input logic rst, input logic [4:0] op, input logic mr,
                     input logic stp, input logic [18:0] strb,
                     input logic [4:0] alu, input logic run);
    vec_t v;
    v.rst = rst; v.op = op; v.mr = mr; v.stp = stp;
    v.strb = strb; v.alu = alu; v.run = run;
    vecs.push_back(v);
  endtask

  // Normal-flow cycle: no reset, no stop.
  task automatic cyc(input logic [4:0] op, input logic mr,
                     input logic [18:0] strb, input logic [4:0] alu, input logic run);
    add(1'b0, op, mr, 1'b0, strb, alu, run);
  endtask

  task automatic fetch(input logic [4:0] op);
    cyc(op, 1'b1, F_T0, 5'd0, 1'b1);
    cyc(op, 1'b1, F_T1, 5'd0, 1'b1);
    cyc(op, 1'b1, F_T2, 5'd0, 1'b1);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (vec %0d): got %0h, expected %0h", name, idx, got, exp);
    end
  endtask

  function automatic logic [18:0] strobes();
    return {bus_if.PCout, bus_if.PCin, bus_if.IncPC, bus_if.MARin, bus_if.MDRin,
            bus_if.MDRout, bus_if.Read, bus_if.Write, bus_if.IRin, bus_if.Yin,
            bus_if.Zin, bus_if.Zlowout, bus_if.Cout, bus_if.Gra, bus_if.Grb,
            bus_if.Grc, bus_if.Rin, bus_if.Rout, bus_if.BAout};
  endfunction

  initial begin
    bus_if.IR        = 32'h0;
    bus_if.mem_ready = 1'b0;
    bus_if.stop      = 1'b0;

    // Leaving reset: RST for one cycle, then add (6 cycles, no waits).
    cyc(OP_ADD, 1'b1, NONE, 5'd0, 1'b0);
    fetch(OP_ADD);
    cyc(OP_ADD, 1'b1, M_GRB | M_ROUT | M_YIN, 5'd0, 1'b1);
    cyc(OP_ADD, 1'b1, M_GRC | M_ROUT | M_ZIN, OP_ADD, 1'b1);
    cyc(OP_ADD, 1'b1, M_ZLOWOUT | M_GRA | M_RIN, 5'd0, 1'b1);

    // ldi.
    fetch(OP_LDI);
    cyc(OP_LDI, 1'b1, M_GRB | M_BAOUT | M_YIN, 5'd0, 1'b1);
    cyc(OP_LDI, 1'b1, M_COUT | M_ZIN, 5'b00011, 1'b1);
    cyc(OP_LDI, 1'b1, M_ZLOWOUT | M_GRA | M_RIN, 5'd0, 1'b1);

    // andi: ALU code maps to and.
    fetch(OP_ANDI);
    cyc(OP_ANDI, 1'b1, M_GRB | M_ROUT | M_YIN, 5'd0, 1'b1);
    cyc(OP_ANDI, 1'b1, M_COUT | M_ZIN, 5'b00101, 1'b1);
    cyc(OP_ANDI, 1'b1, M_ZLOWOUT | M_GRA | M_RIN, 5'd0, 1'b1);

    // ld: 3 wait cycles in T1, 2 in T6, 13 cycles in all. IR holds a halt
    // opcode during T0 and the first T1 cycle; it must not matter.
    cyc(OP_HALT, 1'b1, F_T0, 5'd0, 1'b1);
    cyc(OP_HALT, 1'b0, F_T1, 5'd0, 1'b1);
    cyc(OP_LD,   1'b0, F_T1, 5'd0, 1'b1);
    cyc(OP_LD,   1'b0, F_T1, 5'd0, 1'b1);
    cyc(OP_LD,   1'b1, F_T1, 5'd0, 1'b1);
    cyc(OP_LD,   1'b1, F_T2, 5'd0, 1'b1);
    cyc(OP_LD,   1'b1, M_GRB | M_BAOUT | M_YIN, 5'd0, 1'b1);
    cyc(OP_LD,   1'b1, M_COUT | M_ZIN, 5'b00011, 1'b1);
    cyc(OP_LD,   1'b1, M_ZLOWOUT | M_MARIN, 5'd0, 1'b1);
    cyc(OP_LD,   1'b0, M_READ | M_MDRIN, 5'd0, 1'b1);
    cyc(OP_LD,   1'b0, M_READ | M_MDRIN, 5'd0, 1'b1);
    cyc(OP_LD,   1'b1, M_READ | M_MDRIN, 5'd0, 1'b1);
    cyc(OP_LD,   1'b1, M_MDROUT | M_GRA | M_RIN, 5'd0, 1'b1);

    // st: T6 drives ra into MDR without Read, T7 Write held for 2 waits.
    fetch(OP_ST);
    cyc(OP_ST, 1'b1, M_GRB | M_BAOUT | M_YIN, 5'd0, 1'b1);
    cyc(OP_ST, 1'b1, M_COUT | M_ZIN, 5'b00011, 1'b1);
    cyc(OP_ST, 1'b1, M_ZLOWOUT | M_MARIN, 5'd0, 1'b1);
    cyc(OP_ST, 1'b0, M_GRA | M_ROUT | M_MDRIN, 5'd0, 1'b1);
    cyc(OP_ST, 1'b0, M_WRITE, 5'd0, 1'b1);
    cyc(OP_ST, 1'b0, M_WRITE, 5'd0, 1'b1);
    cyc(OP_ST, 1'b1, M_WRITE, 5'd0, 1'b1);

    // Unlisted opcode acts as a 3-cycle nop, then halt opcode ends in HALT.
    fetch(OP_UNK);
    fetch(OP_HALT);
    add(1'b0, OP_ADD, 1'b1, 1'b1, NONE, 5'd0, 1'b0);
    cyc(OP_ADD, 1'b0, NONE, 5'd0, 1'b0);
    add(1'b1, OP_ADD, 1'b1, 1'b0, NONE, 5'd0, 1'b0);
    cyc(OP_SUB, 1'b1, NONE, 5'd0, 1'b0);

    // sub with stop pulsed in T3: sub completes, then HALT for 20 cycles.
    fetch(OP_SUB);
    add(1'b0, OP_SUB, 1'b1, 1'b1, M_GRB | M_ROUT | M_YIN, 5'd0, 1'b1);
    cyc(OP_SUB, 1'b1, M_GRC | M_ROUT | M_ZIN, OP_SUB, 1'b1);
    cyc(OP_SUB, 1'b1, M_ZLOWOUT | M_GRA | M_RIN, 5'd0, 1'b1);
    for (int i = 0; i < 20; i++) cyc(OP_ADD, i[0], NONE, 5'd0, 1'b0);
    add(1'b1, OP_ADD, 1'b1, 1'b0, NONE, 5'd0, 1'b0);
    cyc(OP_LD, 1'b1, NONE, 5'd0, 1'b0);

    // ld interrupted by reset in the T6 wait, with stop and mem_ready high.
    fetch(OP_LD);
    cyc(OP_LD, 1'b1, M_GRB | M_BAOUT | M_YIN, 5'd0, 1'b1);
    cyc(OP_LD, 1'b1, M_COUT | M_ZIN, 5'b00011, 1'b1);
    cyc(OP_LD, 1'b1, M_ZLOWOUT | M_MARIN, 5'd0, 1'b1);
    cyc(OP_LD, 1'b0, M_READ | M_MDRIN, 5'd0, 1'b1);
    add(1'b1, OP_LD, 1'b1, 1'b1, M_READ | M_MDRIN, 5'd0, 1'b1);
    cyc(OP_UNK, 1'b1, NONE, 5'd0, 1'b0);
    // The stop seen at the reset edge must have been discarded.
    fetch(OP_UNK);
    cyc(OP_UNK, 1'b1, F_T0, 5'd0, 1'b1);

    // Two cycles of reset bring the sequencer to RST before the table.
    repeat (2) @(posedge clock);

    foreach (vecs[i]) begin
      logic [18:0] s;
      @(negedge clock);
      reset            = vecs[i].rst;
      bus_if.IR        = {vecs[i].op, 27'h5a5a5a5};
      bus_if.mem_ready = vecs[i].mr;
      bus_if.stop      = vecs[i].stp;
      #1;
      s = strobes();
      check("strobes", i, 32'(s), 32'(vecs[i].strb));
      check("alu_op", i, 32'(bus_if.alu_op), 32'(vecs[i].alu));
      check("Run", i, 32'(bus_if.Run), 32'(vecs[i].run));
      check("ra_rb_rc_onehot", i,
            32'(32'(bus_if.Gra) + 32'(bus_if.Grb) + 32'(bus_if.Grc) > 1), 32'd0);
      check("rin_conflict", i,
            32'(bus_if.Rin & (bus_if.Rout | bus_if.BAout)), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
